// File: rtl/veri_bellegi_yanitlayici.sv
// Data-memory responder: accepts one load/store at a time, waits GECIKME cycles,
// then performs a RISC-V B/H/W access on an internal word RAM and strobes completion.
module veri_bellegi_yanitlayici #(
  parameter int          ADRES_BIT   = 10,
  parameter logic [31:0] TABAN_ADRES = 32'h8000_0000,
  parameter int          GECIKME     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        onbellekten_oku_i,
  input  logic        onbellege_yaz_i,
  input  logic [31:0] adres_i,
  input  logic [31:0] veri_i,
  input  logic [2:0]  buyruk_turu_i,
  output logic [31:0] veri_o,
  output logic        veri_hazir_o,
  output logic        denetim_hazir_o,
  output logic        hata_o,
  output logic [1:0]  durum_o
);

  // Handshake: a request is taken on the edge where (oku | yaz) & denetim_hazir_o;
  // the initiator keeps it asserted until the one-cycle veri_hazir_o pulse.

  localparam int SAYAC_BIT = (GECIKME > 1) ? $clog2(GECIKME) : 1;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    BEKLE = 2'd1,
    YANIT = 2'd2
  } durum_t;

  durum_t                durum_q, durum_d;
  logic [SAYAC_BIT-1:0]  sayac_q, sayac_d;
  logic [31:0]           adres_q, adres_d;
  logic [31:0]           veri_q, veri_d;
  logic [2:0]            tur_q, tur_d;
  logic                  oku_q, oku_d;
  logic                  yaz_q, yaz_d;
  logic [31:0]           cikis_q, cikis_d;
  logic                  hazir_q, hazir_d;
  logic                  denetim_q, denetim_d;
  logic                  hata_q, hata_d;

  logic [31:0]           ram [2**ADRES_BIT];

  logic [31:0]           ofs;
  logic [ADRES_BIT-1:0]  idx;
  logic [31:0]           kelime;
  logic [31:0]           yazilacak;
  logic [31:0]           okunan;
  logic [7:0]            bayt;
  logic [15:0]           yarim;
  logic                  aralik_disi;
  logic                  hizasiz;
  logic                  tur_gecersiz;
  logic                  erisim_hata;
  logic                  ram_yaz_en;

  // Decode of the latched request; only consumed at the commit edge.
  always_comb begin
    ofs          = adres_q - TABAN_ADRES;
    idx          = ofs[ADRES_BIT+1:2];
    kelime       = ram[idx];
    aralik_disi  = (ofs[31:ADRES_BIT+2] != '0);
    hizasiz      = ((tur_q[1:0] == 2'b01) && ofs[0]) ||
                   ((tur_q[1:0] == 2'b10) && (ofs[1:0] != 2'b00));
    tur_gecersiz = (tur_q == 3'b011) || (tur_q == 3'b110) || (tur_q == 3'b111) ||
                   (yaz_q && tur_q[2]);
    erisim_hata  = aralik_disi || hizasiz || tur_gecersiz || (oku_q && yaz_q);

    bayt  = kelime[{ofs[1:0], 3'b000} +: 8];
    yarim = kelime[{ofs[1], 4'b0000} +: 16];

    yazilacak = kelime;
    case (tur_q[1:0])
      2'b00:   yazilacak[{ofs[1:0], 3'b000} +: 8] = veri_q[7:0];
      2'b01:   yazilacak[{ofs[1], 4'b0000} +: 16] = veri_q[15:0];
      default: yazilacak = veri_q;
    endcase

    case (tur_q)
      3'b000:  okunan = {{24{bayt[7]}}, bayt};
      3'b100:  okunan = {24'd0, bayt};
      3'b001:  okunan = {{16{yarim[15]}}, yarim};
      3'b101:  okunan = {16'd0, yarim};
      default: okunan = kelime;
    endcase
  end

  always_comb begin
    durum_d    = durum_q;
    sayac_d    = sayac_q;
    adres_d    = adres_q;
    veri_d     = veri_q;
    tur_d      = tur_q;
    oku_d      = oku_q;
    yaz_d      = yaz_q;
    cikis_d    = cikis_q;
    hazir_d    = 1'b0;
    denetim_d  = denetim_q;
    hata_d     = hata_q;
    ram_yaz_en = 1'b0;

    case (durum_q)
      BOSTA: begin
        if (denetim_q && (onbellekten_oku_i || onbellege_yaz_i)) begin
          adres_d   = adres_i;
          veri_d    = veri_i;
          tur_d     = buyruk_turu_i;
          oku_d     = onbellekten_oku_i;
          yaz_d     = onbellege_yaz_i;
          sayac_d   = SAYAC_BIT'(GECIKME - 1);
          denetim_d = 1'b0;
          durum_d   = BEKLE;
        end else begin
          denetim_d = 1'b1;
        end
      end
      BEKLE: begin
        if (sayac_q == '0) begin
          ram_yaz_en = yaz_q && !erisim_hata;
          hata_d     = erisim_hata;
          cikis_d    = (erisim_hata || yaz_q) ? 32'd0 : okunan;
          hazir_d    = 1'b1;
          durum_d    = YANIT;
        end else begin
          sayac_d = sayac_q - 1'b1;
        end
      end
      YANIT: begin
        denetim_d = 1'b1;
        durum_d   = BOSTA;
      end
      default: begin
        denetim_d = 1'b0;
        durum_d   = BOSTA;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q   <= BOSTA;
      sayac_q   <= '0;
      adres_q   <= '0;
      veri_q    <= '0;
      tur_q     <= '0;
      oku_q     <= 1'b0;
      yaz_q     <= 1'b0;
      cikis_q   <= '0;
      hazir_q   <= 1'b0;
      denetim_q <= 1'b0;
      hata_q    <= 1'b0;
    end else begin
      durum_q   <= durum_d;
      sayac_q   <= sayac_d;
      adres_q   <= adres_d;
      veri_q    <= veri_d;
      tur_q     <= tur_d;
      oku_q     <= oku_d;
      yaz_q     <= yaz_d;
      cikis_q   <= cikis_d;
      hazir_q   <= hazir_d;
      denetim_q <= denetim_d;
      hata_q    <= hata_d;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (ram_yaz_en) begin
      ram[idx] <= yazilacak;
    end
  end

  assign veri_o          = cikis_q;
  assign veri_hazir_o    = hazir_q;
  assign denetim_hazir_o = denetim_q;
  assign hata_o          = hata_q;
  assign durum_o         = durum_q;

endmodule

// File: tb/tb_veri_bellegi_yanitlayici.sv
// Directed bench for veri_bellegi_yanitlayici: lanes, errors, timing, reset abort
// and back-to-back throughput with GECIKME = 2.
module tb_veri_bellegi_yanitlayici;

  logic        clk;
  logic        rst;
  logic        oku;
  logic        yaz;
  logic [31:0] adres;
  logic [31:0] veri;
  logic [2:0]  tur;
  logic [31:0] veri_o;
  logic        veri_hazir;
  logic        denetim_hazir;
  logic        hata;
  logic [1:0]  durum;

  int kontrol_sayisi = 0;
  int hata_sayisi    = 0;

  localparam logic [2:0] T_B = 3'b000, T_H = 3'b001, T_W = 3'b010,
                         T_BU = 3'b100, T_X = 3'b011;

  veri_bellegi_yanitlayici #(
    .ADRES_BIT(10), .TABAN_ADRES(32'h8000_0000), .GECIKME(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .onbellekten_oku_i(oku), .onbellege_yaz_i(yaz),
    .adres_i(adres), .veri_i(veri), .buyruk_turu_i(tur),
    .veri_o(veri_o), .veri_hazir_o(veri_hazir),
    .denetim_hazir_o(denetim_hazir), .hata_o(hata), .durum_o(durum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    kontrol_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic bosta_bekle();
    for (int i = 0; i < 50; i++) begin
      if (denetim_hazir) return;
      @(negedge clk);
    end
    kontrol("idle_timeout", 32'd0, 32'd1);
  endtask

  // Issues one request from a falling edge and waits for its completion pulse.
  task automatic islem(input logic o, input logic y, input logic [31:0] a,
                       input logic [31:0] v, input logic [2:0] t,
                       output logic [31:0] d, output logic h);
    logic alindi;
    alindi = 1'b0;
    d = 32'hx;
    h = 1'bx;
    @(negedge clk);
    bosta_bekle();
    oku = o; yaz = y; adres = a; veri = v; tur = t;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (veri_hazir) begin
        d = veri_o;
        h = hata;
        alindi = 1'b1;
        break;
      end
    end
    oku = 1'b0; yaz = 1'b0;
    if (!alindi) kontrol("strobe_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] d;
  logic        h;
  logic [11:0] hazir_iz, denetim_iz;
  int          darbe;

  initial begin
    rst = 1'b1; oku = 1'b0; yaz = 1'b0; adres = '0; veri = '0; tur = T_W;
    repeat (3) @(negedge clk);
    kontrol("rst_veri_o", veri_o, 32'd0);
    kontrol("rst_hazir", {31'd0, veri_hazir}, 32'd0);
    kontrol("rst_denetim", {31'd0, denetim_hazir}, 32'd0);
    kontrol("rst_hata", {31'd0, hata}, 32'd0);
    kontrol("rst_durum", {30'd0, durum}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    kontrol("denetim_after_rst", {31'd0, denetim_hazir}, 32'd1);

    // Basic SW with cycle-exact timing; cycle 0 is the acceptance cycle.
    bosta_bekle();
    yaz = 1'b1; adres = 32'h8000_0010; veri = 32'hDEAD_BEEF; tur = T_W;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      kontrol($sformatf("sw_hazir_c%0d", c), {31'd0, veri_hazir}, {31'd0, c == 3});
      kontrol($sformatf("sw_denetim_c%0d", c), {31'd0, denetim_hazir}, {31'd0, c == 4});
      if (c == 3) begin
        kontrol("sw_hata", {31'd0, hata}, 32'd0);
        kontrol("sw_veri_o", veri_o, 32'd0);
        kontrol("sw_durum_yanit", {30'd0, durum}, 32'd2);
        yaz = 1'b0;
      end
    end
    islem(1, 0, 32'h8000_0010, 0, T_W, d, h);
    kontrol("lw_basic", d, 32'hDEAD_BEEF);
    kontrol("lw_basic_hata", {31'd0, h}, 32'd0);

    // Byte lane
    islem(0, 1, 32'h8000_0013, 32'h0000_00A5, T_B, d, h);
    kontrol("sb_hata", {31'd0, h}, 32'd0);
    islem(1, 0, 32'h8000_0013, 0, T_B, d, h);
    kontrol("lb", d, 32'hFFFF_FFA5);
    islem(1, 0, 32'h8000_0013, 0, T_BU, d, h);
    kontrol("lbu", d, 32'h0000_00A5);
    islem(1, 0, 32'h8000_0010, 0, T_W, d, h);
    kontrol("lw_after_sb", d, 32'hA5AD_BEEF);

    // Halfword lane and misalignment
    islem(0, 1, 32'h8000_0012, 32'h0000_1234, T_H, d, h);
    kontrol("sh_hata", {31'd0, h}, 32'd0);
    islem(1, 0, 32'h8000_0012, 0, T_H, d, h);
    kontrol("lh", d, 32'h0000_1234);
    islem(1, 0, 32'h8000_0010, 0, T_W, d, h);
    kontrol("lw_after_sh", d, 32'h1234_BEEF);
    islem(1, 0, 32'h8000_0011, 0, T_H, d, h);
    kontrol("lh_misalign_hata", {31'd0, h}, 32'd1);
    kontrol("lh_misalign_veri", d, 32'd0);

    // Range and type errors, last word seeded first
    islem(0, 1, 32'h8000_0FFC, 32'hCAFE_F00D, T_W, d, h);
    kontrol("sw_top_hata", {31'd0, h}, 32'd0);
    islem(1, 0, 32'h0000_0000, 0, T_W, d, h);
    kontrol("lw_low_range", {31'd0, h}, 32'd1);
    kontrol("lw_low_range_veri", d, 32'd0);
    islem(0, 1, 32'h8000_1000, 32'hFFFF_FFFF, T_W, d, h);
    kontrol("sw_high_range", {31'd0, h}, 32'd1);
    islem(1, 0, 32'h8000_0010, 0, T_X, d, h);
    kontrol("load_type_011", {31'd0, h}, 32'd1);
    kontrol("load_type_011_veri", d, 32'd0);
    islem(1, 1, 32'h8000_0FFC, 32'hFFFF_FFFF, T_W, d, h);
    kontrol("rd_wr_together", {31'd0, h}, 32'd1);
    islem(0, 1, 32'h8000_0010, 32'hFFFF_FFFF, T_BU, d, h);
    kontrol("store_bu", {31'd0, h}, 32'd1);
    islem(1, 0, 32'h8000_0FFC, 0, T_W, d, h);
    kontrol("lw_top_kept", d, 32'hCAFE_F00D);
    islem(1, 0, 32'h8000_0010, 0, T_W, d, h);
    kontrol("lw_0x10_kept", d, 32'h1234_BEEF);

    // Reset mid-operation drops the uncommitted store
    islem(0, 1, 32'h8000_0020, 32'h1111_1111, T_W, d, h);
    islem(1, 0, 32'h8000_0020, 0, T_W, d, h);
    kontrol("lw_1111", d, 32'h1111_1111);
    @(negedge clk);
    bosta_bekle();
    yaz = 1'b1; adres = 32'h8000_0020; veri = 32'h5555_5555; tur = T_W;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    kontrol("midrst_veri_o", veri_o, 32'd0);
    kontrol("midrst_hazir", {31'd0, veri_hazir}, 32'd0);
    kontrol("midrst_denetim", {31'd0, denetim_hazir}, 32'd0);
    kontrol("midrst_hata", {31'd0, hata}, 32'd0);
    kontrol("midrst_durum", {30'd0, durum}, 32'd0);
    yaz = 1'b0;
    #1 rst = 1'b0;
    islem(1, 0, 32'h8000_0020, 0, T_W, d, h);
    kontrol("lw_after_midrst", d, 32'h1111_1111);

    // Back-to-back: read held for 12 cycles
    @(negedge clk);
    bosta_bekle();
    oku = 1'b1; adres = 32'h8000_0010; tur = T_W;
    darbe = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      hazir_iz[c-1]   = veri_hazir;
      denetim_iz[c-1] = denetim_hazir;
      if (veri_hazir) begin
        darbe++;
        kontrol($sformatf("b2b_veri_c%0d", c), veri_o, 32'h1234_BEEF);
      end
    end
    oku = 1'b0;
    kontrol("b2b_hazir_pattern", {20'd0, hazir_iz}, {20'd0, 12'b0100_0100_0100});
    kontrol("b2b_denetim_pattern", {20'd0, denetim_iz}, {20'd0, 12'b1000_1000_1000});
    kontrol("b2b_pulse_count", darbe, 32'd3);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", kontrol_sayisi, hata_sayisi);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/veri_bellegi_yanitlayici.md
# veri_bellegi_yanitlayici

Responder end of the core's data-memory port: accepts read/write requests from the memory stage, performs RISC-V byte/half/word accesses on an internal word-organised RAM after a programmable latency, and returns load data and a completion strobe. It sits outside the core, wired directly to the memory stage's `vbellek_*` signals. It serves as the data cache/RAM model for FPGA builds and as the bench target for memory-stage verification.

## Interface
- `ADRES_BIT`, 10 — word-address width; capacity is 2^ADRES_BIT words, which is 4 KiB at the default.
- `TABAN_ADRES`, 32'h8000_0000 — byte base address of the RAM.
- `GECIKME`, 2 — wait cycles between acceptance and data commit; must be ≥1.
- `clk_i` in 1 — single clock; all logic on rising edge.
- `rst_i` in 1 — reset, asynchronous, active-high.
- `onbellekten_oku_i` in 1 — read request.
- `onbellege_yaz_i` in 1 — write request.
- `adres_i` in 32 — byte address.
- `veri_i` in 32 — store data; the LSBs are used for byte and halfword stores.
- `buyruk_turu_i` in 3 — access type, RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `veri_o` out 32 — load result, extended to 32 bits.
- `veri_hazir_o` out 1 — one-cycle completion pulse, for both reads and writes.
- `denetim_hazir_o` out 1 — idle and able to accept a request.
- `hata_o` out 1 — error flag, valid only while `veri_hazir_o` is high.

## Operation
- FSM states:
  - BOSTA: `denetim_hazir_o` = 1 while `rst_i` = 0.
  - BEKLE: counting down the latency.
  - YANIT: `veri_hazir_o` = 1.
- Acceptance:
  - A request is accepted at the rising edge where (`onbellekten_oku_i` | `onbellege_yaz_i`) & `denetim_hazir_o` = 1.
  - On acceptance, latch address, type, data and operation; load the counter with GECIKME-1; go to BEKLE.
  - Requests are ignored outside BOSTA. The initiator holds its request until `veri_hazir_o`.
- BEKLE:
  - Decrement the counter each cycle.
  - At the edge where counter = 0, commit the access and go to YANIT.
  - `veri_o` and `hata_o` are registered at that same edge.
- YANIT: lasts one cycle, then returns to BOSTA unconditionally.
- Address handling:
  - offset = `adres_i` − TABAN_ADRES (32-bit unsigned). In range when offset < 4·2^ADRES_BIT.
  - Word index = offset[ADRES_BIT+1:2].
- Stores:
  - SB writes `veri_i`[7:0] to byte offset[1:0].
  - SH writes `veri_i`[15:0] to half offset[1].
  - SW writes the full word.
  - Other bytes of the word are preserved.
- Loads:
  - LB / LBU: byte selected by offset[1:0], sign- or zero-extended.
  - LH / LHU: half selected by offset[1], sign- or zero-extended.
  - LW: full word.
- Error conditions (`hata_o` = 1):
  - Out-of-range address.
  - Misaligned access: H/HU with offset[0] = 1, W with offset[1:0] ≠ 0.
  - Undefined type: 011, 110, 111, or BU/HU used on a write.
  - Read and write requested together; the access is treated as a write.
- On error: no RAM write and `veri_o` = 0; the strobe is still issued.
- After a successful write, `veri_o` = 0.
- `veri_o` holds its value until the next commit.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset values:
  - State BOSTA.
  - `veri_o` = 0, `veri_hazir_o` = 0, `hata_o` = 0.
  - `denetim_hazir_o` = 0 while `rst_i` is high; it is 1 from the first cycle after release.
- Latency: for a request accepted at the edge ending cycle T, `veri_hazir_o` is high in cycle T+GECIKME+1.
  - `denetim_hazir_o` is low from T+1 through T+GECIKME+1, and high again in T+GECIKME+2.
- Throughput: one access per GECIKME+2 cycles when requests are held continuously.
- Reset asserted mid-operation:
  - Immediately returns to BOSTA with outputs at their reset values.
  - A write not yet committed is dropped; the RAM keeps its old value.
- `veri_hazir_o` never stays high for two consecutive cycles.

## Test plan
Settings for all scenarios: GECIKME = 2, ADRES_BIT = 10, TABAN_ADRES = 0x8000_0000.

- **Basic write/read:** SW 0x8000_0010 ← 0xDEADBEEF, accepted cycle 0 → `veri_hazir_o` high only in cycle 3, `hata_o` = 0, `denetim_hazir_o` high again in cycle 4. A following LW of the same address returns 0xDEADBEEF.
- **Byte lane:** SB 0x8000_0013 ← 0x0000_00A5. Then:
  - LB returns 0xFFFF_FFA5.
  - LBU returns 0x0000_00A5.
  - LW returns 0xA5AD_BEEF.
- **Halfword lane and misalignment:** SH 0x8000_0012 ← 0x0000_1234. Then:
  - LH returns 0x0000_1234.
  - LW returns 0x1234_BEEF.
  - LH 0x8000_0011 gives `hata_o` = 1 with `veri_o` = 0.
- **Range and type errors:** each of the following gives `hata_o` = 1:
  - LW 0x0000_0000.
  - SW 0x8000_1000 ← 0xFFFF_FFFF.
  - Load of type 011.
  - Read and write asserted together.

  Afterwards, LW 0x8000_0FFC returns its prior contents, and LW 0x8000_0010 still returns 0x1234_BEEF.
- **Reset mid-operation:** SW 0x8000_0020 ← 0x1111_1111 completes. SW 0x8000_0020 ← 0x5555_5555 is accepted in cycle 0, and `rst_i` is pulsed in cycle 1, mid-clock → all outputs go to 0 asynchronously. After release, LW 0x8000_0020 returns 0x1111_1111.
- **Back-to-back requests:** a read request held high for 12 cycles → `veri_hazir_o` pulses exactly every 4 cycles, and no request is accepted while `denetim_hazir_o` = 0.
